// File: rtl/ram_datapath_unit_if.sv
// Control word and observation bus between the control unit and the datapath.
// Combinational only; no storage.
// No flow control: the control unit presents a new word every cycle.
interface ram_datapath_unit_if;
  logic        W;
  logic [4:0]  DA;
  logic [4:0]  SA;
  logic [4:0]  SB;
  logic [63:0] K;
  logic        K_SEL;
  logic [4:0]  FS;
  logic        C0;
  logic        EN_ALU;
  logic        EN_B;
  logic        EN_ADDR;
  logic        CS;
  logic        WE;
  logic        OE;
  logic        PC_SEL;
  logic [63:0] CU;
  logic [3:0]  Status;
  logic [63:0] r0;
  logic [63:0] r1;
  logic [63:0] r2;
  logic [63:0] r3;
  logic [63:0] r4;
  logic [63:0] r5;
  logic [63:0] r6;
  logic [63:0] r7;
  logic [63:0] PC_in;

  modport master (
    output W, DA, SA, SB, K, K_SEL, FS, C0, EN_ALU, EN_B, EN_ADDR,
           CS, WE, OE, PC_SEL, CU,
    input  Status, r0, r1, r2, r3, r4, r5, r6, r7, PC_in
  );

  modport slave (
    input  W, DA, SA, SB, K, K_SEL, FS, C0, EN_ALU, EN_B, EN_ADDR,
           CS, WE, OE, PC_SEL, CU,
    output Status, r0, r1, r2, r3, r4, r5, r6, r7, PC_in
  );
endinterface

// File: rtl/ram_datapath_unit.sv
// 64-bit single-cycle datapath: 32x64 register file, ALU, 4096x64 data RAM, D bus.
// Reads/ALU/PC_in combinational; register and RAM writes take effect at the next edge.
// No backpressure: one control word is consumed every clock.
module ram_datapath_unit (
  input  logic                  clk,
  input  logic                  rst,
  ram_datapath_unit_if.slave    bus
);

  logic [63:0] regs [0:31];
  logic [63:0] mem  [0:4095];

  logic [63:0] a_val;
  logic [63:0] b_val;
  logic [63:0] b_mux;
  logic [63:0] a_inv;
  logic [63:0] b_inv;
  logic [64:0] sum;
  logic [63:0] f_val;
  logic        carry;
  logic        ovf;
  logic [63:0] ram_out;
  logic [63:0] d_bus;

  // X31 is the zero register: reads return 0 regardless of storage.
  assign a_val = (bus.SA == 5'd31) ? 64'h0 : regs[bus.SA];
  assign b_val = (bus.SB == 5'd31) ? 64'h0 : regs[bus.SB];

  assign b_mux = bus.K_SEL ? bus.K : b_val;
  assign a_inv = bus.FS[0] ? ~a_val : a_val;
  assign b_inv = bus.FS[1] ? ~b_mux : b_mux;
  assign sum   = {1'b0, a_inv} + {1'b0, b_inv} + {64'h0, bus.C0};

  // ALU result and flags; carry/overflow only meaningful for the adder.
  always_comb begin
    f_val = 64'h0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (bus.FS[4:2])
      3'b000: f_val = a_inv & b_inv;
      3'b001: f_val = a_inv | b_inv;
      3'b010: begin
        f_val = sum[63:0];
        carry = sum[64];
        ovf   = (a_inv[63] == b_inv[63]) && (sum[63] != a_inv[63]);
      end
      3'b011: f_val = a_inv ^ b_inv;
      3'b100: f_val = a_val << b_mux[5:0];
      3'b101: f_val = a_val >> b_mux[5:0];
      default: f_val = 64'h0;
    endcase
  end

  assign bus.Status = {ovf, carry, f_val[63], (f_val == 64'h0)};

  // RAM is word addressed by the low 12 bits of the ALU result.
  assign ram_out = mem[f_val[11:0]];

  // Priority mux replacing the shared tristate bus.
  always_comb begin
    d_bus = 64'h0;
    if (bus.EN_ALU)
      d_bus = f_val;
    else if (bus.EN_B)
      d_bus = b_val;
    else if (bus.EN_ADDR && bus.CS && bus.OE)
      d_bus = ram_out;
  end

  assign bus.PC_in = bus.PC_SEL ? a_val : bus.CU;

  // Register file write; reset clears the whole file, writes to X31 are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= 64'h0;
    end else if (bus.W && (bus.DA != 5'd31)) begin
      regs[bus.DA] <= d_bus;
    end
  end

  // RAM write is independent of reset so contents survive a datapath reset.
  always_ff @(posedge clk) begin
    if (bus.CS && bus.WE)
      mem[f_val[11:0]] <= b_val;
  end

  assign bus.r0 = regs[0];
  assign bus.r1 = regs[1];
  assign bus.r2 = regs[2];
  assign bus.r3 = regs[3];
  assign bus.r4 = regs[4];
  assign bus.r5 = regs[5];
  assign bus.r6 = regs[6];
  assign bus.r7 = regs[7];

endmodule

// File: tb/tb_ram_datapath_unit.sv
// Randomised and directed bench for ram_datapath_unit with a queue-based scoreboard.
// Expected values come from an array-based reference model of the datapath.
// A negedge monitor pops and compares entries due in the current cycle.
module tb_ram_datapath_unit;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  ram_datapath_unit_if bus ();

  ram_datapath_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    string       name;
    int          sel;
    logic [63:0] val;
  } exp_t;

  exp_t        sb [$];
  logic [63:0] mreg [0:31];
  logic [63:0] mmem [int];
  logic [11:0] stored [$];

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      0: return bus.r0;
      1: return bus.r1;
      2: return bus.r2;
      3: return bus.r3;
      4: return bus.r4;
      5: return bus.r5;
      6: return bus.r6;
      7: return bus.r7;
      8: return {60'h0, bus.Status};
      default: return bus.PC_in;
    endcase
  endfunction

  task automatic push(input int due, input string name, input int sel, input logic [63:0] val);
    exp_t e;
    e.due = due; e.name = name; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due in this cycle, away from the clock edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        logic [63:0] act;
        act = observe(sb[i].sel);
        checks++;
        if (sb[i].due != cyc || act !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc %0d got %h expected %h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  function automatic void alu_model(input logic [63:0] a, input logic [63:0] bm,
                                    input logic [4:0] fs, input logic c0,
                                    output logic [63:0] f, output logic [3:0] st);
    logic [63:0] x, y;
    logic [64:0] wide;
    logic signed [65:0] sx;
    logic c, v;
    x = fs[0] ? ~a : a;
    y = fs[1] ? ~bm : bm;
    c = 1'b0; v = 1'b0;
    case (fs[4:2])
      3'd0: f = x & y;
      3'd1: f = x | y;
      3'd2: begin
        wide = {1'b0, x} + {1'b0, y} + 65'(c0);
        f = wide[63:0];
        c = wide[64];
        sx = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed({65'h0, c0});
        v = (sx > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (sx < -66'sh0_8000_0000_0000_0000);
      end
      3'd3: f = x ^ y;
      3'd4: f = a << bm[5:0];
      3'd5: f = a >> bm[5:0];
      default: f = 64'h0;
    endcase
    st = {v, c, f[63], (f == 64'h0)};
  endfunction

  function automatic logic [63:0] mem_rd(input logic [11:0] addr);
    if (mmem.exists(int'(addr))) return mmem[int'(addr)];
    return 'x;
  endfunction

  task automatic clear_cw();
    bus.W = 0; bus.DA = 0; bus.SA = 5'd31; bus.SB = 5'd31; bus.K = 0; bus.K_SEL = 0;
    bus.FS = 0; bus.C0 = 0; bus.EN_ALU = 0; bus.EN_B = 0; bus.EN_ADDR = 0;
    bus.CS = 0; bus.WE = 0; bus.OE = 0; bus.PC_SEL = 0; bus.CU = 0;
  endtask

  // Issue the current control word for one cycle, predicting its effects.
  task automatic apply();
    logic [63:0] a, b, bm, f, d;
    logic [3:0]  st;
    a  = (bus.SA == 5'd31) ? 64'h0 : mreg[bus.SA];
    b  = (bus.SB == 5'd31) ? 64'h0 : mreg[bus.SB];
    bm = bus.K_SEL ? bus.K : b;
    alu_model(a, bm, bus.FS, bus.C0, f, st);
    if (bus.EN_ALU)                             d = f;
    else if (bus.EN_B)                          d = b;
    else if (bus.EN_ADDR && bus.CS && bus.OE)   d = mem_rd(f[11:0]);
    else                                        d = 64'h0;
    push(cyc, "status", 8, {60'h0, st});
    push(cyc, "pc_in", 9, bus.PC_SEL ? a : bus.CU);
    if (!rst) begin
      for (int i = 0; i < 32; i++) mreg[i] = 64'h0;
    end else if (bus.W && bus.DA != 5'd31) begin
      mreg[bus.DA] = d;
    end
    if (bus.CS && bus.WE) begin
      mmem[int'(f[11:0])] = b;
      stored.push_back(f[11:0]);
    end
    for (int k = 0; k < 8; k++) push(cyc + 1, $sformatf("r%0d", k), k, mreg[k]);
    @(posedge clk); #1;
  endtask

  logic [63:0] kvals [4];

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mreg[i] = 64'h0;
    kvals[0] = 64'h0000FFFF0000000F;
    kvals[1] = 64'hFFFF0000000000F0;
    kvals[2] = 64'h0123456789ABCDEF;
    kvals[3] = 64'hCCCCCCCCCCCCCCCC;
    clear_cw();
    rst = 1'b0;
    @(posedge clk); #1;
    apply();
    apply();
    push(cyc, "reset_r0", 0, 64'h0);
    push(cyc, "reset_r7", 7, 64'h0);
    rst = 1'b1;

    // ADDI X0..X3 from the zero register.
    for (int i = 0; i < 4; i++) begin
      clear_cw();
      bus.SA = 5'd31; bus.K_SEL = 1; bus.FS = 5'b01000; bus.EN_ALU = 1; bus.W = 1;
      bus.DA = 5'(i); bus.K = kvals[i];
      apply();
      push(cyc, $sformatf("addi_x%0d", i), i, kvals[i]);
    end

    checks++;
    if (bus.r0 !== 64'h0000FFFF0000000F) begin
      errors++;
      $display("FAIL direct_addi_r0 got %h", bus.r0);
    end
    checks++;
    if (bus.r1 !== 64'hFFFF0000000000F0) begin
      errors++;
      $display("FAIL direct_addi_r1 got %h", bus.r1);
    end
    checks++;
    if (bus.r2 !== 64'h0123456789ABCDEF) begin
      errors++;
      $display("FAIL direct_addi_r2 got %h", bus.r2);
    end
    checks++;
    if (bus.r3 !== 64'hCCCCCCCCCCCCCCCC) begin
      errors++;
      $display("FAIL direct_addi_r3 got %h", bus.r3);
    end

    // SUBI X4 = X1 - all-ones.
    clear_cw();
    bus.SA = 5'd1; bus.K = '1; bus.K_SEL = 1; bus.FS = 5'b01010; bus.C0 = 1;
    bus.EN_ALU = 1; bus.W = 1; bus.DA = 5'd4;
    push(cyc, "sub_status", 8, 64'h2);
    apply();
    push(cyc, "sub_r4", 4, 64'hFFFF0000000000F1);

    // MOV X5 = X1, then MOV from X31 clears it.
    clear_cw();
    bus.SB = 5'd1; bus.EN_B = 1; bus.W = 1; bus.DA = 5'd5;
    apply();
    push(cyc, "mov_r5", 5, 64'hFFFF0000000000F0);
    bus.SB = 5'd31;
    apply();
    push(cyc, "mov_zero_r5", 5, 64'h0);

    // STUR X2,[X0]; STUR X3,[X1].
    for (int i = 0; i < 2; i++) begin
      clear_cw();
      bus.SA = 5'(i); bus.SB = 5'(i + 2); bus.K_SEL = 1; bus.FS = 5'b01000;
      bus.EN_B = 1; bus.CS = 1; bus.WE = 1;
      apply();
    end

    // LDUR X6,[X0]; LDUR X7,[X1].
    for (int i = 0; i < 2; i++) begin
      clear_cw();
      bus.SA = 5'(i); bus.K_SEL = 1; bus.FS = 5'b01000;
      bus.EN_ADDR = 1; bus.CS = 1; bus.OE = 1; bus.W = 1; bus.DA = 5'(6 + i);
      apply();
      push(cyc, $sformatf("ldur_x%0d", 6 + i), 6 + i, kvals[2 + i]);
    end

    checks++;
    if (bus.r6 !== 64'h0123456789ABCDEF) begin
      errors++;
      $display("FAIL direct_ldur_r6 got %h", bus.r6);
    end
    checks++;
    if (bus.r7 !== 64'hCCCCCCCCCCCCCCCC) begin
      errors++;
      $display("FAIL direct_ldur_r7 got %h", bus.r7);
    end

    // BR X6, then PC from the control unit.
    clear_cw();
    bus.PC_SEL = 1; bus.SA = 5'd6;
    push(cyc, "br_pc", 9, 64'h0123456789ABCDEF);
    apply();
    checks++;
    if (bus.PC_in !== 64'h0123456789ABCDEF) begin
      errors++;
      $display("FAIL direct_br_pc got %h", bus.PC_in);
    end
    bus.PC_SEL = 0; bus.CU = 64'hA5A5_0000_1234_5678;
    push(cyc, "cu_pc", 9, 64'hA5A5_0000_1234_5678);
    apply();

    // Mid-run reset clears the register file but not the RAM.
    clear_cw();
    rst = 1'b0;
    apply();
    push(cyc, "midreset_r3", 3, 64'h0);
    rst = 1'b1;
    clear_cw();
    bus.SA = 5'd31; bus.K = 64'h00F; bus.K_SEL = 1; bus.FS = 5'b01000;
    bus.EN_ADDR = 1; bus.CS = 1; bus.OE = 1; bus.W = 1; bus.DA = 5'd2;
    apply();
    push(cyc, "ram_kept", 2, 64'h0123456789ABCDEF);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      int mode;
      clear_cw();
      mode = $urandom_range(0, 3);
      bus.PC_SEL = 1'($urandom); bus.SA = 5'($urandom); bus.SB = 5'($urandom);
      bus.DA = 5'($urandom); bus.CU = {$urandom, $urandom};
      bus.K = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) bus.K = 64'($urandom_range(0, 70));
      case (mode)
        0: begin
          bus.FS = 5'($urandom); bus.C0 = 1'($urandom); bus.K_SEL = 1'($urandom);
          bus.EN_ALU = 1; bus.W = 1'($urandom); bus.EN_B = 1'($urandom);
          bus.EN_ADDR = 1'($urandom); bus.CS = 1'($urandom); bus.OE = 1'($urandom);
        end
        1: begin
          bus.EN_B = 1; bus.W = 1; bus.FS = 5'($urandom); bus.K_SEL = 1'($urandom);
        end
        2: begin
          bus.K_SEL = 1; bus.FS = 5'b01000; bus.EN_B = 1; bus.CS = 1; bus.WE = 1;
          bus.OE = 1'($urandom);
        end
        default: begin
          if (stored.size() > 0) begin
            bus.SA = 5'd31; bus.K_SEL = 1; bus.FS = 5'b01000;
            bus.K[11:0] = stored[$urandom_range(0, stored.size() - 1)];
            bus.EN_ADDR = 1; bus.CS = 1; bus.OE = 1; bus.W = 1;
            bus.WE = 1'($urandom);
          end
        end
      endcase
      rst = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      apply();
    end
    rst = 1'b1;
    clear_cw();

    // Drain: anything still queued after the bound was never checked.
    repeat (3) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s unchecked due %0d expected %h", sb[0].name, sb[0].due, sb[0].val);
      void'(sb.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
